trg_pls_sched: RTL and testbench

- Trigger-pulse scheduler in the CLK160M domain, between the SPI command decoder and the TRG_PLS outputs of the pulse-match datapath.
- Accepts 32-bit command words over a valid/ready handshake. Holds per-channel delay, width, period and count settings, and runs one independent pulse-train FSM per channel.
- Supports coordinated multi-channel arm and abort.

---
 rtl/trg_pls_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_trg_pls_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trg_pls_sched.sv
// Trigger-pulse scheduler: command-word configured, per-channel delay/width/period/count
// pulse-train generators with coordinated multi-channel arm and abort.
module trg_pls_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
) (
    input  logic           CLK160M,
    input  logic           RESET,
    input  logic           CMD_VALID,
    output logic           CMD_READY,
    input  logic [31:0]    CMD_DATA,
    output logic [NCH-1:0] TRG_PLS,
    output logic [NCH-1:0] BUSY,
    output logic [NCH-1:0] DONE,
    output logic           CMD_ERR
);

    typedef enum logic [1:0] {StIdle, StWait, StHigh, StLow} state_e;

    localparam logic [3:0] OpDelay  = 4'd0;
    localparam logic [3:0] OpWidth  = 4'd1;
    localparam logic [3:0] OpPeriod = 4'd2;
    localparam logic [3:0] OpCount  = 4'd3;
    localparam logic [3:0] OpArm    = 4'd4;
    localparam logic [3:0] OpAbort  = 4'd5;

    localparam logic [CW-1:0] One  = CW'(1);
    localparam logic [CW:0]   OneX = (CW + 1)'(1);

    logic [3:0]     op;
    logic [1:0]     ch;
    logic [CW-1:0]  value;
    logic [NCH-1:0] mask;
    logic           unused_data;

    assign op          = CMD_DATA[31:28];
    assign ch          = CMD_DATA[27:26];
    assign value       = CMD_DATA[CW-1:0];
    assign mask        = CMD_DATA[NCH-1:0];
    assign unused_data = ^CMD_DATA;

    logic           ch_ok;
    logic           ch_busy;
    logic           is_cfg;
    logic           is_arm;
    logic           is_abort;
    logic           is_err;
    logic           ready;
    logic           accept;

    // Configuration registers
    logic [CW-1:0]  delay_q  [NCH];
    logic [CW-1:0]  width_q  [NCH];
    logic [CW-1:0]  period_q [NCH];
    logic [CW-1:0]  count_q  [NCH];

    // Effective (clamped) timing derived from the configuration
    logic [CW-1:0]  w_eff    [NCH];
    logic [CW:0]    p_min    [NCH];
    logic [CW:0]    p_eff    [NCH];
    logic [CW-1:0]  low_len  [NCH];

    // Working state per channel
    state_e         state_q  [NCH];
    state_e         state_d  [NCH];
    logic [CW-1:0]  phase_q  [NCH];
    logic [CW-1:0]  phase_d  [NCH];
    logic [CW-1:0]  rem_q    [NCH];
    logic [CW-1:0]  rem_d    [NCH];
    logic [CW-1:0]  wlen_q   [NCH];
    logic [CW-1:0]  wlen_d   [NCH];
    logic [CW-1:0]  llen_q   [NCH];
    logic [CW-1:0]  llen_d   [NCH];

    logic [NCH-1:0] trg_q,  trg_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] done_q, done_d;
    logic           err_q;

    assign ch_ok = {30'd0, ch} < NCH;

    always_comb begin
        ch_busy = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (2'(i) == ch) ch_busy = busy_q[i];
        end
    end

    assign is_cfg   = (op <= OpCount) && ch_ok;
    assign is_arm   = (op == OpArm);
    assign is_abort = (op == OpAbort);
    assign is_err   = (op > OpAbort) || ((op <= OpCount) && !ch_ok);

    // Stall only config writes to a busy channel and ARMs overlapping busy channels.
    always_comb begin
        ready = 1'b1;
        if (op <= OpCount) begin
            ready = !(ch_ok && ch_busy);
        end else if (is_arm) begin
            ready = ((mask & busy_q) == '0);
        end
        if (RESET) ready = 1'b0;
    end

    assign accept = CMD_VALID && ready;

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                delay_q[i]  <= '0;
                width_q[i]  <= One;
                period_q[i] <= CW'(2);
                count_q[i]  <= One;
            end
        end else if (accept && is_cfg) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (2'(i) == ch) begin
                    case (op)
                        OpDelay:  delay_q[i]  <= value;
                        OpWidth:  width_q[i]  <= value;
                        OpPeriod: period_q[i] <= value;
                        OpCount:  count_q[i]  <= value;
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Peff is computed one bit wider so WIDTH = 2^CW-1 cannot overflow Weff+1.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            w_eff[i]   = (width_q[i] == '0) ? One : width_q[i];
            p_min[i]   = {1'b0, w_eff[i]} + OneX;
            p_eff[i]   = ({1'b0, period_q[i]} < p_min[i]) ? p_min[i] : {1'b0, period_q[i]};
            low_len[i] = CW'(p_eff[i] - {1'b0, w_eff[i]});
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        wlen_d  = wlen_q;
        llen_d  = llen_q;
        trg_d   = '0;
        busy_d  = '0;
        done_d  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (accept && is_arm && mask[i]) begin
                wlen_d[i] = w_eff[i];
                llen_d[i] = low_len[i];
                rem_d[i]  = count_q[i];
                if (delay_q[i] == '0) begin
                    state_d[i] = StHigh;
                    phase_d[i] = w_eff[i] - One;
                end else begin
                    state_d[i] = StWait;
                    phase_d[i] = delay_q[i] - One;
                end
            end else if (accept && is_abort && mask[i]) begin
                state_d[i] = StIdle;
            end else begin
                case (state_q[i])
                    StWait: begin
                        if (phase_q[i] == '0) begin
                            state_d[i] = StHigh;
                            phase_d[i] = wlen_q[i] - One;
                        end else begin
                            phase_d[i] = phase_q[i] - One;
                        end
                    end
                    StHigh: begin
                        if (phase_q[i] != '0) begin
                            phase_d[i] = phase_q[i] - One;
                        end else if (rem_q[i] == One) begin
                            state_d[i] = StIdle;
                            done_d[i]  = 1'b1;
                        end else begin
                            // rem == 0 is continuous mode and is left untouched
                            if (rem_q[i] != '0) rem_d[i] = rem_q[i] - One;
                            state_d[i] = StLow;
                            phase_d[i] = llen_q[i] - One;
                        end
                    end
                    StLow: begin
                        if (phase_q[i] == '0) begin
                            state_d[i] = StHigh;
                            phase_d[i] = wlen_q[i] - One;
                        end else begin
                            phase_d[i] = phase_q[i] - One;
                        end
                    end
                    default: ;
                endcase
            end
            trg_d[i]  = (state_d[i] == StHigh);
            busy_d[i] = (state_d[i] != StIdle);
        end
    end

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= StIdle;
                phase_q[i] <= '0;
                rem_q[i]   <= '0;
                wlen_q[i]  <= '0;
                llen_q[i]  <= '0;
            end
            trg_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            wlen_q  <= wlen_d;
            llen_q  <= llen_d;
            trg_q   <= trg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= accept && is_err;
        end
    end

    assign CMD_READY = ready;
    assign TRG_PLS   = trg_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_trg_pls_sched.sv
// Directed bench for trg_pls_sched: a 4-channel instance for the main scenarios and a
// 3-channel instance for the out-of-range channel case.
module tb_trg_pls_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_err;
    logic [31:0] cmd_data;
    logic [3:0]  trg, busy, done;
    logic        cmd_valid3, cmd_ready3, cmd_err3;
    logic [31:0] cmd_data3;
    logic [2:0]  trg3, busy3, done3;

    int checks = 0;
    int errors = 0;

    logic [15:0] et, eb, ed;

    always #5 clk = ~clk;

    trg_pls_sched #(.NCH(4), .CW(16)) dut (
        .CLK160M  (clk),
        .RESET    (rst),
        .CMD_VALID(cmd_valid),
        .CMD_READY(cmd_ready),
        .CMD_DATA (cmd_data),
        .TRG_PLS  (trg),
        .BUSY     (busy),
        .DONE     (done),
        .CMD_ERR  (cmd_err)
    );

    trg_pls_sched #(.NCH(3), .CW(16)) dut3 (
        .CLK160M  (clk),
        .RESET    (rst),
        .CMD_VALID(cmd_valid3),
        .CMD_READY(cmd_ready3),
        .CMD_DATA (cmd_data3),
        .TRG_PLS  (trg3),
        .BUSY     (busy3),
        .DONE     (done3),
        .CMD_ERR  (cmd_err3)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] ch,
                                       input logic [15:0] v);
        return {op, ch, 10'd0, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command until accepted (bounded); returns one tick after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] d, input string tag);
        bit ok;
        ok = 1'b0;
        if (sel) begin cmd_valid3 = 1'b1; cmd_data3 = d; end
        else     begin cmd_valid  = 1'b1; cmd_data  = d; end
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = ((sel ? cmd_ready3 : cmd_ready) === 1'b1);
            @(posedge clk);
            #1;
        end
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b1;
        cmd_data   = mk(4'd5, 2'd0, 16'h000f);
        cmd_valid3 = 1'b0;
        cmd_data3  = '0;
        step(3);
        chk("rst_trg",   32'(trg),       32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_err",   32'(cmd_err),   32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        step(1);

        // Single train on ch0: D=3 W=2 P=5 C=2
        send(0, mk(4'd0, 2'd0, 16'd3), "t1_cfg_d");
        send(0, mk(4'd1, 2'd0, 16'd2), "t1_cfg_w");
        send(0, mk(4'd2, 2'd0, 16'd5), "t1_cfg_p");
        send(0, mk(4'd3, 2'd0, 16'd2), "t1_cfg_c");
        send(0, mk(4'd4, 2'd0, 16'h0001), "t1_arm");
        et = 16'b0000_0110_0011_0000;
        eb = 16'b0000_0111_1111_1110;
        ed = 16'b0000_1000_0000_0000;
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("t1_trg_k%0d", k),  32'(trg[0]),  32'(et[k]));
            chk($sformatf("t1_busy_k%0d", k), 32'(busy[0]), 32'(eb[k]));
            chk($sformatf("t1_done_k%0d", k), 32'(done[0]), 32'(ed[k]));
            step(1);
        end

        // Clamps on ch1: W=0 P=0 D=0 C=3
        send(0, mk(4'd1, 2'd1, 16'd0), "t2_cfg_w");
        send(0, mk(4'd2, 2'd1, 16'd0), "t2_cfg_p");
        send(0, mk(4'd0, 2'd1, 16'd0), "t2_cfg_d");
        send(0, mk(4'd3, 2'd1, 16'd3), "t2_cfg_c");
        send(0, mk(4'd4, 2'd0, 16'h0002), "t2_arm");
        et = 16'b0000_0000_0010_1010;
        eb = 16'b0000_0000_0011_1110;
        ed = 16'b0000_0000_0100_0000;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t2_trg_k%0d", k),  32'(trg[1]),  32'(et[k]));
            chk($sformatf("t2_busy_k%0d", k), 32'(busy[1]), 32'(eb[k]));
            chk($sformatf("t2_done_k%0d", k), 32'(done[1]), 32'(ed[k]));
            step(1);
        end

        // Stall and abort on ch2 running continuously with default timing
        send(0, mk(4'd3, 2'd2, 16'd0), "t3_cfg_c");
        send(0, mk(4'd4, 2'd0, 16'h0004), "t3_arm");
        step(8);
        chk("t3_busy_cont", 32'(busy[2]), 32'h1);
        cmd_valid = 1'b1;
        cmd_data  = mk(4'd1, 2'd2, 16'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_stall_%0d", k), 32'(cmd_ready), 32'h0);
            step(1);
        end
        cmd_valid = 1'b0;
        send(0, mk(4'd5, 2'd0, 16'h0004), "t3_abort");
        chk("t3_abort_trg",  32'(trg[2]),  32'h0);
        chk("t3_abort_busy", 32'(busy[2]), 32'h0);
        chk("t3_abort_done", 32'(done[2]), 32'h0);
        step(1);
        chk("t3_abort_done2", 32'(done[2]), 32'h0);
        send(0, mk(4'd1, 2'd2, 16'd3), "t3_held_w");
        send(0, mk(4'd3, 2'd2, 16'd1), "t3_cfg_c1");
        send(0, mk(4'd4, 2'd0, 16'h0004), "t3_rearm");
        et = 16'b0000_0000_0000_1110;
        ed = 16'b0000_0000_0001_0000;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t3_w3_trg_k%0d", k),  32'(trg[2]),  32'(et[k]));
            chk($sformatf("t3_w3_done_k%0d", k), 32'(done[2]), 32'(ed[k]));
            step(1);
        end

        // Multi-channel arm of ch0 and ch3 with equal configs: D=2 W=2 P=4 C=3
        for (int c = 0; c < 4; c += 3) begin
            send(0, mk(4'd0, 2'(c), 16'd2), "t4_cfg_d");
            send(0, mk(4'd1, 2'(c), 16'd2), "t4_cfg_w");
            send(0, mk(4'd2, 2'(c), 16'd4), "t4_cfg_p");
            send(0, mk(4'd3, 2'(c), 16'd3), "t4_cfg_c");
        end
        send(0, mk(4'd4, 2'd0, 16'h0009), "t4_arm");
        et = 16'b0001_1001_1001_1000;
        eb = 16'b0001_1111_1111_1110;
        ed = 16'b0010_0000_0000_0000;
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) begin
                cmd_valid = 1'b1;
                cmd_data  = mk(4'd4, 2'd0, 16'h0001);
                chk("t4_arm_stall", 32'(cmd_ready), 32'h0);
                cmd_valid = 1'b0;
            end
            chk($sformatf("t4_trg_k%0d", k),  32'({trg[3], trg[0]}),   32'({et[k], et[k]}));
            chk($sformatf("t4_busy_k%0d", k), 32'({busy[3], busy[0]}), 32'({eb[k], eb[k]}));
            chk($sformatf("t4_done_k%0d", k), 32'({done[3], done[0]}), 32'({ed[k], ed[k]}));
            step(1);
        end

        // Errors and no-op commands
        send(0, mk(4'd7, 2'd1, 16'h0009), "t5_op7");
        chk("t5_op7_err", 32'(cmd_err), 32'h1);
        step(1);
        chk("t5_op7_err_off", 32'(cmd_err), 32'h0);
        send(0, mk(4'd4, 2'd0, 16'h0002), "t5_arm_ch1");
        et = 16'b0000_0000_0010_1010;
        ed = 16'b0000_0000_0100_0000;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t5_ch1_trg_k%0d", k),  32'(trg[1]),  32'(et[k]));
            chk($sformatf("t5_ch1_done_k%0d", k), 32'(done[1]), 32'(ed[k]));
            step(1);
        end
        send(0, mk(4'd5, 2'd0, 16'h000f), "t5_abort_idle");
        chk("t5_abort_idle_busy", 32'(busy), 32'h0);
        chk("t5_abort_idle_done", 32'(done), 32'h0);
        chk("t5_abort_idle_err",  32'(cmd_err), 32'h0);
        send(0, mk(4'd4, 2'd0, 16'h0000), "t5_arm_zero");
        chk("t5_arm_zero_busy", 32'(busy), 32'h0);
        send(1, mk(4'd0, 2'd3, 16'h0007), "t5_ch3_nch3");
        chk("t5_ch3_err", 32'(cmd_err3), 32'h1);
        step(1);
        chk("t5_ch3_err_off", 32'(cmd_err3), 32'h0);
        send(1, mk(4'd4, 2'd0, 16'h0005), "t5_arm3");
        chk("t5_arm3_trg",  32'(trg3),  32'h5);
        chk("t5_arm3_busy", 32'(busy3), 32'h5);
        step(1);
        chk("t5_arm3_trg2",  32'(trg3),  32'h0);
        chk("t5_arm3_done2", 32'(done3), 32'h5);

        // Reset mid-train, then defaults give one 1-cycle pulse
        send(0, mk(4'd1, 2'd0, 16'd5), "t6_cfg_w");
        send(0, mk(4'd0, 2'd0, 16'd0), "t6_cfg_d");
        send(0, mk(4'd3, 2'd0, 16'd1), "t6_cfg_c");
        send(0, mk(4'd4, 2'd0, 16'h0001), "t6_arm");
        step(1);
        chk("t6_pre_trg", 32'(trg[0]), 32'h1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_trg",   32'(trg),       32'h0);
        chk("t6_rst_busy",  32'(busy),      32'h0);
        chk("t6_rst_done",  32'(done),      32'h0);
        chk("t6_rst_err",   32'(cmd_err),   32'h0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'h0);
        rst = 1'b0;
        step(1);
        send(0, mk(4'd4, 2'd0, 16'h0001), "t6_arm_dflt");
        chk("t6_dflt_trg1",  32'(trg[0]),  32'h1);
        chk("t6_dflt_busy1", 32'(busy[0]), 32'h1);
        step(1);
        chk("t6_dflt_trg2",  32'(trg[0]),  32'h0);
        chk("t6_dflt_busy2", 32'(busy[0]), 32'h0);
        chk("t6_dflt_done2", 32'(done[0]), 32'h1);
        step(1);
        chk("t6_dflt_done3", 32'(done[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
